// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, redirect/stall/flush
// priority handling, misaligned-target pulse and a count of valid fetches.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h00400000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instruction_i,
    input  logic        Stall_i,
    input  logic        Flush_i,
    input  logic        Branch_taken_i,
    input  logic [31:0] Branch_target_i,
    output logic [31:0] Pc_o,
    output logic [31:0] IfId_Pc_o,
    output logic [31:0] IfId_Pc_plus4_o,
    output logic [31:0] IfId_Instruction_o,
    output logic        IfId_Valid_o,
    output logic        Misaligned_o,
    output logic [31:0] Fetch_count_o
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] pc_plus4;
    logic        load_bubble;

    // Natural 32-bit wrap: 0xFFFFFFFC advances to 0 with no flag.
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        // NOTE: every next-state signal gets a hold/default value first so no latch is inferred.
        pc_d          = pc_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_pc4_d    = ifid_pc4_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_valid_d  = ifid_valid_q;
        misaligned_d  = 1'b0;
        fetch_count_d = fetch_count_q;
        load_bubble   = 1'b0;

        if (Branch_taken_i) begin
            pc_d         = {Branch_target_i[31:2], 2'b00};
            misaligned_d = |Branch_target_i[1:0];
            load_bubble  = 1'b1;
        end else if (Stall_i && Flush_i) begin
            load_bubble = 1'b1;
        end else if (Stall_i) begin
            // Hold everything, including the valid bit.
            pc_d = pc_q;
        end else if (Flush_i) begin
            pc_d        = pc_plus4;
            load_bubble = 1'b1;
        end else begin
            pc_d          = pc_plus4;
            ifid_pc_d     = pc_q;
            ifid_pc4_d    = pc_plus4;
            ifid_instr_d  = Instruction_i;
            ifid_valid_d  = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
        end

        if (load_bubble) begin
            ifid_pc_d    = '0;
            ifid_pc4_d   = '0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
        if (reset) begin
            pc_q          <= RESET_PC;
            ifid_pc_q     <= '0;
            ifid_pc4_q    <= '0;
            ifid_instr_q  <= NOP_INSTR;
            ifid_valid_q  <= 1'b0;
            misaligned_q  <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_pc4_q    <= ifid_pc4_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_valid_q  <= ifid_valid_d;
            misaligned_q  <= misaligned_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign Pc_o               = pc_q;
    assign IfId_Pc_o          = ifid_pc_q;
    assign IfId_Pc_plus4_o    = ifid_pc4_q;
    assign IfId_Instruction_o = ifid_instr_q;
    assign IfId_Valid_o       = ifid_valid_q;
    assign Misaligned_o       = misaligned_q;
    assign Fetch_count_o      = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed stimulus pushes hand-computed
// expected states, a monitor pops and compares them against the DUT outputs.
module tb_instruction_fetch_unit;

    typedef struct {
        bit          dut_b;
        string       tag;
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] ipc4;
        logic [31:0] instr;
        logic        valid;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    localparam logic [31:0] NOP = 32'h00000013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default reset PC
    logic        reset_a;
    logic [31:0] instr_a;
    logic        stall_a, flush_a, br_a;
    logic [31:0] tgt_a;
    logic [31:0] pc_a, ipc_a, ipc4_a, iinstr_a, cnt_a;
    logic        valid_a, mis_a;

    // DUT B: reset PC at the top of the address space
    logic        reset_b;
    logic [31:0] instr_b;
    logic [31:0] pc_b, ipc_b, ipc4_b, iinstr_b, cnt_b;
    logic        valid_b, mis_b;

    // Program memory: word at address p reads as {C0DE, p[15:0]}.
    assign instr_a = {16'hC0DE, pc_a[15:0]};
    assign instr_b = {16'hC0DE, pc_b[15:0]};

    instruction_fetch_unit u_dut_a (
        .clk                (clk),
        .reset              (reset_a),
        .Instruction_i      (instr_a),
        .Stall_i            (stall_a),
        .Flush_i            (flush_a),
        .Branch_taken_i     (br_a),
        .Branch_target_i    (tgt_a),
        .Pc_o               (pc_a),
        .IfId_Pc_o          (ipc_a),
        .IfId_Pc_plus4_o    (ipc4_a),
        .IfId_Instruction_o (iinstr_a),
        .IfId_Valid_o       (valid_a),
        .Misaligned_o       (mis_a),
        .Fetch_count_o      (cnt_a)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFFFFFC)) u_dut_b (
        .clk                (clk),
        .reset              (reset_b),
        .Instruction_i      (instr_b),
        .Stall_i            (1'b0),
        .Flush_i            (1'b0),
        .Branch_taken_i     (1'b0),
        .Branch_target_i    (32'h0),
        .Pc_o               (pc_b),
        .IfId_Pc_o          (ipc_b),
        .IfId_Pc_plus4_o    (ipc4_b),
        .IfId_Instruction_o (iinstr_b),
        .IfId_Valid_o       (valid_b),
        .Misaligned_o       (mis_b),
        .Fetch_count_o      (cnt_b)
    );

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    event sample_now;

    task automatic push(input bit b, input string tag, input logic [31:0] pc, ipc, ipc4, instr,
                        input logic v, m, input logic [31:0] cnt);
        exp_t e;
        e.dut_b = b; e.tag = tag; e.pc = pc; e.ipc = ipc; e.ipc4 = ipc4;
        e.instr = instr; e.valid = v; e.mis = m; e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    // Drive one edge's worth of inputs on DUT A, then record the state expected after that edge.
    task automatic step(input logic st, fl, br, input logic [31:0] tgt, input string tag,
                        input logic [31:0] pc, ipc, ipc4, instr,
                        input logic v, m, input logic [31:0] cnt);
        stall_a = st; flush_a = fl; br_a = br; tgt_a = tgt;
        @(posedge clk);
        #1;
        push(1'b0, tag, pc, ipc, ipc4, instr, v, m, cnt);
    endtask

    // Monitor: compares every queued expectation at the falling edge or on demand.
    initial begin
        forever begin
            @(negedge clk or sample_now);
            while (sb_q.size() > 0) begin
                exp_t e;
                logic [31:0] a_pc, a_ipc, a_ipc4, a_instr, a_cnt;
                logic        a_v, a_m;
                e = sb_q.pop_front();
                if (e.dut_b) begin
                    a_pc = pc_b; a_ipc = ipc_b; a_ipc4 = ipc4_b; a_instr = iinstr_b;
                    a_v = valid_b; a_m = mis_b; a_cnt = cnt_b;
                end else begin
                    a_pc = pc_a; a_ipc = ipc_a; a_ipc4 = ipc4_a; a_instr = iinstr_a;
                    a_v = valid_a; a_m = mis_a; a_cnt = cnt_a;
                end
                n_cmp++;
                if (a_pc !== e.pc || a_ipc !== e.ipc || a_ipc4 !== e.ipc4 || a_instr !== e.instr ||
                    a_v !== e.valid || a_m !== e.mis || a_cnt !== e.cnt) begin
                    n_err++;
                    $display("FAIL %s: got pc=%h ifpc=%h ifpc4=%h instr=%h v=%b mis=%b cnt=%0d, expected pc=%h ifpc=%h ifpc4=%h instr=%h v=%b mis=%b cnt=%0d",
                             e.tag, a_pc, a_ipc, a_ipc4, a_instr, a_v, a_m, a_cnt,
                             e.pc, e.ipc, e.ipc4, e.instr, e.valid, e.mis, e.cnt);
                end
            end
        end
    end

    initial begin
        reset_a = 1'b1; reset_b = 1'b1;
        stall_a = 1'b0; flush_a = 1'b0; br_a = 1'b0; tgt_a = 32'h0;

        @(posedge clk);
        #1;
        push(1'b0, "reset_a", 32'h00400000, 32'h0, 32'h0, NOP, 1'b0, 1'b0, 32'd0);
        push(1'b1, "reset_b", 32'hFFFFFFFC, 32'h0, 32'h0, NOP, 1'b0, 1'b0, 32'd0);
        reset_a = 1'b0;

        //    st    fl    br    target        tag            Pc_o          IfId_Pc       IfId_Pc+4     IfId_Instr    V     Mis   count
        step(1'b0, 1'b0, 1'b0, 32'h0,        "fetch0",      32'h00400004, 32'h00400000, 32'h00400004, 32'hC0DE0000, 1'b1, 1'b0, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0,        "fetch1",      32'h00400008, 32'h00400004, 32'h00400008, 32'hC0DE0004, 1'b1, 1'b0, 32'd2);
        step(1'b1, 1'b0, 1'b0, 32'h0,        "stall1",      32'h00400008, 32'h00400004, 32'h00400008, 32'hC0DE0004, 1'b1, 1'b0, 32'd2);
        step(1'b1, 1'b0, 1'b0, 32'h0,        "stall2",      32'h00400008, 32'h00400004, 32'h00400008, 32'hC0DE0004, 1'b1, 1'b0, 32'd2);
        step(1'b1, 1'b0, 1'b0, 32'h0,        "stall3",      32'h00400008, 32'h00400004, 32'h00400008, 32'hC0DE0004, 1'b1, 1'b0, 32'd2);
        step(1'b0, 1'b0, 1'b0, 32'h0,        "resume",      32'h0040000C, 32'h00400008, 32'h0040000C, 32'hC0DE0008, 1'b1, 1'b0, 32'd3);
        step(1'b0, 1'b0, 1'b0, 32'h0,        "fetch3",      32'h00400010, 32'h0040000C, 32'h00400010, 32'hC0DE000C, 1'b1, 1'b0, 32'd4);
        step(1'b1, 1'b1, 1'b0, 32'h0,        "stall_flush", 32'h00400010, 32'h0,        32'h0,        NOP,          1'b0, 1'b0, 32'd4);
        step(1'b0, 1'b1, 1'b0, 32'h0,        "flush",       32'h00400014, 32'h0,        32'h0,        NOP,          1'b0, 1'b0, 32'd4);
        step(1'b0, 1'b0, 1'b0, 32'h0,        "post_flush",  32'h00400018, 32'h00400014, 32'h00400018, 32'hC0DE0014, 1'b1, 1'b0, 32'd5);
        step(1'b1, 1'b0, 1'b1, 32'h00400040, "br_stall",    32'h00400040, 32'h0,        32'h0,        NOP,          1'b0, 1'b0, 32'd5);
        step(1'b0, 1'b0, 1'b0, 32'h0,        "br_target",   32'h00400044, 32'h00400040, 32'h00400044, 32'hC0DE0040, 1'b1, 1'b0, 32'd6);
        step(1'b0, 1'b1, 1'b1, 32'h00400046, "br_misalign", 32'h00400044, 32'h0,        32'h0,        NOP,          1'b0, 1'b1, 32'd6);
        step(1'b0, 1'b0, 1'b0, 32'h0,        "mis_clear",   32'h00400048, 32'h00400044, 32'h00400048, 32'hC0DE0044, 1'b1, 1'b0, 32'd7);
        step(1'b1, 1'b0, 1'b1, 32'h00400083, "br_mis_st",   32'h00400080, 32'h0,        32'h0,        NOP,          1'b0, 1'b1, 32'd7);
        step(1'b1, 1'b0, 1'b0, 32'h0,        "stall_bub",   32'h00400080, 32'h0,        32'h0,        NOP,          1'b0, 1'b0, 32'd7);
        step(1'b0, 1'b0, 1'b0, 32'h0,        "fetch_80",    32'h00400084, 32'h00400080, 32'h00400084, 32'hC0DE0080, 1'b1, 1'b0, 32'd8);

        // Reset between edges while a stalled redirect is pending; checked with no clock edge.
        @(negedge clk);
        #1;
        stall_a = 1'b1; br_a = 1'b1; tgt_a = 32'h00500000;
        #1;
        reset_a = 1'b1;
        #1;
        push(1'b0, "async_reset", 32'h00400000, 32'h0, 32'h0, NOP, 1'b0, 1'b0, 32'd0);
        -> sample_now;
        @(posedge clk);
        #1;
        push(1'b0, "reset_hold", 32'h00400000, 32'h0, 32'h0, NOP, 1'b0, 1'b0, 32'd0);
        reset_a = 1'b0;
        step(1'b0, 1'b0, 1'b0, 32'h0,        "first_fetch", 32'h00400004, 32'h00400000, 32'h00400004, 32'hC0DE0000, 1'b1, 1'b0, 32'd1);

        // DUT B: PC wraps from 0xFFFFFFFC to 0.
        reset_b = 1'b0;
        @(posedge clk);
        #1;
        push(1'b1, "wrap0", 32'h00000000, 32'hFFFFFFFC, 32'h00000000, 32'hC0DEFFFC, 1'b1, 1'b0, 32'd1);
        @(posedge clk);
        #1;
        push(1'b1, "wrap1", 32'h00000004, 32'h00000000, 32'h00000004, 32'hC0DE0000, 1'b1, 1'b0, 32'd2);

        repeat (3) @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have the parameter RESET_PC, default 32'h00400000, the PC value loaded on reset.
REQ-002 The block SHALL have the parameter NOP_INSTR, default 32'h00000013 (addi x0,x0,0), the bubble instruction.
REQ-003 The block SHALL have the port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have the port reset, input, 1 bit, asynchronous, active-high reset.
REQ-005 The block SHALL have the port Instruction_i, input, 32 bits, the combinational instruction read from program memory at Pc_o.
REQ-006 The block SHALL have the port Stall_i, input, 1 bit, the hazard-unit request to hold PC and IF/ID.
REQ-007 The block SHALL have the port Flush_i, input, 1 bit, the request to replace the IF/ID contents with a bubble.
REQ-008 The block SHALL have the port Branch_taken_i, input, 1 bit, the redirect request from EX.
REQ-009 The block SHALL have the port Branch_target_i, input, 32 bits, the redirect address.
REQ-010 The block SHALL have the port Pc_o, output, 32 bits, the current fetch PC, which drives the program-memory address.
REQ-011 The block SHALL have the ports IfId_Pc_o and IfId_Pc_plus4_o, outputs, 32 bits each, the registered PC and PC+4 of the instruction in ID.
REQ-012 The block SHALL have the port IfId_Instruction_o, output, 32 bits, the registered instruction.
REQ-013 The block SHALL have the port IfId_Valid_o, output, 1 bit, set to 1 when the IF/ID entry holds a real instruction.
REQ-014 The block SHALL have the port Misaligned_o, output, 1 bit, a one-cycle pulse when a redirect target has bits [1:0] != 0.
REQ-015 The block SHALL have the port Fetch_count_o, output, 32 bits, the count of valid instructions loaded into IF/ID.

Function
REQ-016 Pc_o SHALL be a register output; the memory read is combinational, so the instruction at Pc_o is captured at the next edge (1-cycle fetch latency to IF/ID).
REQ-017 Each rising edge with reset low SHALL apply exactly one of the following, in priority order.
REQ-018 Priority 1, Branch_taken_i=1: PC <= {Branch_target_i[31:2],2'b00}; IF/ID <= bubble; this case wins over both Stall_i and Flush_i.
REQ-019 Priority 2, Stall_i=1 and Flush_i=1: PC holds; IF/ID <= bubble.
REQ-020 Priority 3, Stall_i=1 only: PC holds and all IF/ID registers hold their values, including valid.
REQ-021 Priority 4, Flush_i=1 only: PC <= PC+4; IF/ID <= bubble.
REQ-022 Priority 5, otherwise: PC <= PC+4; IfId_Pc_o <= PC; IfId_Pc_plus4_o <= PC+4; IfId_Instruction_o <= Instruction_i; IfId_Valid_o <= 1.
REQ-023 A bubble SHALL mean IfId_Instruction_o=NOP_INSTR, IfId_Valid_o=0, IfId_Pc_o=0, and IfId_Pc_plus4_o=0.
REQ-024 PC+4 SHALL be computed modulo 2^32, so 32'hFFFFFFFC advances to 32'h00000000 without a flag.
REQ-025 Misaligned_o SHALL be 1 for the one cycle following an edge that took a redirect with Branch_target_i[1:0] != 0, and 0 otherwise.
REQ-026 Fetch_count_o SHALL increment by 1 only on edges applying REQ-022, and SHALL wrap from 32'hFFFFFFFF to 0.

Reset
REQ-027 Asserting reset SHALL immediately, independent of clk, set Pc_o=RESET_PC, IF/ID to bubble, Misaligned_o=0, and Fetch_count_o=0.
REQ-028 While reset is high, all inputs SHALL be ignored.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL discard the pending operation.
REQ-030 On the first edge after reset deasserts, the block SHALL capture the instruction at RESET_PC per REQ-022.

Verification
REQ-031 Reset release, no stall/flush/branch, memory returns A0,A1,A2 -> Pc_o 0x00400000,0x00400004,0x00400008; IfId_Instruction_o A0 then A1; IfId_Pc_o 0x00400000 then 0x00400004; Fetch_count_o 1,2,3.
REQ-032 Stall_i high for 3 edges at Pc_o=0x00400008 -> Pc_o and all IF/ID outputs unchanged for 3 cycles; Fetch_count_o constant; normal advance resumes on the following edge.
REQ-033 Branch_taken_i=1, target 0x00400040, together with Stall_i=1 -> Pc_o=0x00400040; IfId_Valid_o=0; IfId_Instruction_o=0x00000013; Misaligned_o=0.
REQ-034 Branch target 0x00400046 -> Pc_o=0x00400044; Misaligned_o=1 for exactly one cycle.
REQ-035 Flush_i=1 with Stall_i=1 at Pc_o=0x00400010 -> Pc_o remains 0x00400010; IF/ID becomes bubble. Flush_i=1 alone -> Pc_o advances to 0x00400014 and IF/ID becomes bubble.
REQ-036 RESET_PC=32'hFFFFFFFC -> Pc_o 0xFFFFFFFC then 0x00000000. Reset asserted between edges -> Pc_o returns to RESET_PC without a clock edge.
